// File: rtl/ahb_lite_mst_req.sv
// rtl/ahb_lite_mst_req.sv - valid/ready command stream to pipelined AHB-Lite single transfers
// Optional lane steering of write/read data under LITE_MST_LANE_STEER_EN.
module ahb_lite_mst_req #(
  parameter logic [31:0] HADDR_RST  = 32'h0,
  parameter logic        HWRITE_RST = 1'b0
) (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_vld,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  input  logic        pad_biu_bigend_b,
  output logic        lite_mmc_hsel,
  output logic [31:0] lite_yy_haddr,
  output logic [2:0]  lite_yy_hsize,
  output logic [1:0]  lite_yy_htrans,
  output logic        lite_yy_hwrite,
  output logic [31:0] lite_yy_hwdata,
  input  logic [31:0] mmc_lite_hrdata,
  input  logic        mmc_lite_hready,
  input  logic [1:0]  mmc_lite_hresp
);

  logic        a_vld;
  logic        a_write;
  logic [31:0] a_addr;
  logic [1:0]  a_size;
  logic [31:0] a_wdata;

  logic        d_vld;
  logic        d_write;
  logic [1:0]  d_addr_lo;
  logic [1:0]  d_size;
  logic [31:0] hwdata_q;

  logic        a_done;
  logic        d_done;
  logic        accept;
  logic [1:0]  req_size_eff;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_lane;

  assign a_done       = a_vld & mmc_lite_hready;
  assign d_done       = d_vld & mmc_lite_hready;
  assign req_rdy      = ~a_vld | mmc_lite_hready;
  assign accept       = req_vld & req_rdy;
  // Reserved size encoding is issued as a word transfer.
  assign req_size_eff = (req_size == 2'd3) ? 2'd2 : req_size;

`ifdef LITE_MST_LANE_STEER_EN
  logic [1:0] rd_lane;

  always_comb begin
    case (a_size)
      2'd0:    wdata_lane = {4{a_wdata[7:0]}};
      2'd1:    wdata_lane = {2{a_wdata[15:0]}};
      default: wdata_lane = a_wdata;
    endcase
  end

  // Big-endian mirrors the lane index; bit 1 of the mirror also picks the halfword.
  assign rd_lane = pad_biu_bigend_b ? d_addr_lo : ~d_addr_lo;

  always_comb begin
    case (d_size)
      2'd0:    rdata_lane = {24'h0, mmc_lite_hrdata[{rd_lane, 3'b000} +: 8]};
      2'd1:    rdata_lane = {16'h0, rd_lane[1] ? mmc_lite_hrdata[31:16] : mmc_lite_hrdata[15:0]};
      default: rdata_lane = mmc_lite_hrdata;
    endcase
  end
`else
  assign wdata_lane = a_wdata;
  assign rdata_lane = mmc_lite_hrdata;
  wire unused_steer = &{1'b0, pad_biu_bigend_b, d_addr_lo, d_size};
`endif

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      a_vld   <= 1'b0;
      a_write <= HWRITE_RST;
      a_addr  <= HADDR_RST;
      a_size  <= 2'd0;
      a_wdata <= 32'h0;
    end else if (accept) begin
      a_vld   <= 1'b1;
      a_write <= req_write;
      a_addr  <= req_addr;
      a_size  <= req_size_eff;
      a_wdata <= req_wdata;
    end else if (a_done) begin
      a_vld   <= 1'b0;
    end
  end

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      d_vld     <= 1'b0;
      d_write   <= 1'b0;
      d_addr_lo <= 2'd0;
      d_size    <= 2'd0;
      hwdata_q  <= 32'h0;
    end else if (a_done) begin
      d_vld     <= 1'b1;
      d_write   <= a_write;
      d_addr_lo <= a_addr[1:0];
      d_size    <= a_size;
      if (a_write) hwdata_q <= wdata_lane;
    end else if (d_done) begin
      d_vld     <= 1'b0;
    end
  end

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      rsp_vld   <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_vld <= d_done;
      if (d_done) begin
        rsp_write <= d_write;
        rsp_err   <= (mmc_lite_hresp != 2'b00);
        rsp_rdata <= d_write ? 32'h0 : rdata_lane;
      end
    end
  end

  assign busy           = rsp_vld | a_vld | d_vld;
  assign lite_mmc_hsel  = a_vld;
  assign lite_yy_htrans = a_vld ? 2'b10 : 2'b00;
  assign lite_yy_haddr  = a_addr;
  assign lite_yy_hsize  = {1'b0, a_size};
  assign lite_yy_hwrite = a_write;
  assign lite_yy_hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_mst_req.sv
// tb/tb_ahb_lite_mst_req.sv - transaction-queue model bench for ahb_lite_mst_req
module tb_ahb_lite_mst_req;

`ifdef LITE_MST_LANE_STEER_EN
  localparam bit STEER = 1'b1;
`else
  localparam bit STEER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        be_b = 1'b1;
  logic [31:0] hrdata = 32'h0;
  logic        hready = 1'b1;
  logic [1:0]  hresp = 2'b00;

  logic        req_rdy, rsp_vld, rsp_write, rsp_err, busy, hsel, hwrite;
  logic [31:0] rsp_rdata, haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  always #5 clk = ~clk;

  ahb_lite_mst_req dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .busy(busy), .pad_biu_bigend_b(be_b),
    .lite_mmc_hsel(hsel), .lite_yy_haddr(haddr), .lite_yy_hsize(hsize),
    .lite_yy_htrans(htrans), .lite_yy_hwrite(hwrite), .lite_yy_hwdata(hwdata),
    .mmc_lite_hrdata(hrdata), .mmc_lite_hready(hready), .mmc_lite_hresp(hresp)
  );

  int errors = 0;
  int checks = 0;

  // Outstanding transfers, oldest first; in_data marks one past its address phase.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        in_data;
  } xfer_t;
  xfer_t q[$];

  logic [31:0] m_haddr, m_hwdata, m_rdata;
  logic [1:0]  m_hsize;
  logic        m_hwrite, m_rsp_vld, m_rsp_err, m_rsp_write;

  function automatic logic [31:0] wr_lane(input logic [1:0] size, input logic [31:0] w);
    if (STEER && size == 2'd0) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (STEER && size == 2'd1) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] rd_lane(input logic [1:0] a, input logic [1:0] size,
                                          input logic bb, input logic [31:0] h);
    int off;
    if (STEER && size == 2'd0) begin
      off = bb ? int'(a) : 3 - int'(a);
      return (h >> (8 * off)) & 32'hFF;
    end
    if (STEER && size == 2'd1) begin
      off = (bb ? a[1] : !a[1]) ? 16 : 0;
      return (h >> off) & 32'hFFFF;
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_haddr = 32'h0; m_hsize = 2'd0; m_hwrite = 1'b0; m_hwdata = 32'h0;
    m_rsp_vld = 1'b0; m_rsp_err = 1'b0; m_rsp_write = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic model_step();
    bit    a_ex, rdy;
    xfer_t t;
    if (rst) return;
    a_ex = q.size() > 0 && !q[q.size()-1].in_data;
    rdy  = !a_ex || hready;
    m_rsp_vld = 1'b0;
    if (hready && q.size() > 0 && q[0].in_data) begin
      t = q.pop_front();
      m_rsp_vld   = 1'b1;
      m_rsp_write = t.write;
      m_rsp_err   = (hresp != 2'b00);
      m_rdata     = t.write ? 32'h0 : rd_lane(t.addr[1:0], t.size, be_b, hrdata);
    end
    if (hready) begin
      for (int i = 0; i < q.size(); i++) begin
        t = q[i];
        if (!t.in_data) begin
          t.in_data = 1'b1;
          q[i] = t;
          if (t.write) m_hwdata = wr_lane(t.size, t.wdata);
        end
      end
    end
    if (req_vld && rdy) begin
      t = '{write: req_write, addr: req_addr, size: (req_size == 2'd3) ? 2'd2 : req_size,
            wdata: req_wdata, in_data: 1'b0};
      q.push_back(t);
      m_haddr = req_addr; m_hsize = t.size; m_hwrite = req_write;
    end
    checks++;
    if (q.size() > 2) begin
      errors++;
      $display("FAIL outstanding: got %0d expected <=2", q.size());
    end
  endtask

  task automatic compare();
    bit a_ex;
    a_ex = q.size() > 0 && !q[q.size()-1].in_data;
    chk("req_rdy", 32'(req_rdy), 32'(!a_ex || hready));
    chk("hsel",    32'(hsel),    32'(a_ex));
    chk("htrans",  32'(htrans),  a_ex ? 32'h2 : 32'h0);
    chk("haddr",   haddr,        m_haddr);
    chk("hsize",   32'(hsize),   32'(m_hsize));
    chk("hwrite",  32'(hwrite),  32'(m_hwrite));
    chk("hwdata",  hwdata,       m_hwdata);
    chk("rsp_vld", 32'(rsp_vld), 32'(m_rsp_vld));
    chk("busy",    32'(busy),    32'(m_rsp_vld || q.size() > 0));
    if (m_rsp_vld) begin
      chk("rsp_write", 32'(rsp_write), 32'(m_rsp_write));
      chk("rsp_err",   32'(rsp_err),   32'(m_rsp_err));
      chk("rsp_rdata", rsp_rdata,      m_rdata);
    end
  endtask

  task automatic drive(input bit vld, input bit wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] wd,
                       input bit hr, input logic [1:0] rsp, input logic [31:0] rd);
    req_vld = vld; req_write = wr; req_addr = addr; req_size = size; req_wdata = wd;
    hready = hr; hresp = rsp; hrdata = rd;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'b00, 32'h0);
  endtask

  task automatic settle();
    #4;
    compare();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic steer_read(input logic [31:0] addr, input logic [1:0] size,
                            input logic bb, input logic [31:0] exp_steer, input string name);
    be_b = bb;
    drive(1, 0, addr, size, 32'h0, 1, 2'b00, 32'h0); settle(); adv();
    idle(); settle(); adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'b00, 32'h1122_3344); settle(); adv();
    idle(); settle();
    chk(name, rsp_rdata, STEER ? exp_steer : 32'h1122_3344);
    adv();
  endtask

  initial begin
    model_reset();
    idle();
    // reset held, then idle
    settle(); adv(); settle(); adv();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(); settle();
      chk("idle_htrans", 32'(htrans), 32'h0);
      chk("idle_hsel", 32'(hsel), 32'h0);
      chk("idle_haddr", haddr, 32'h0);
      chk("idle_req_rdy", 32'(req_rdy), 32'h1);
      chk("idle_rsp_vld", 32'(rsp_vld), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      adv();
    end

    // write then read back-to-back, zero wait
    drive(1, 1, 32'h10, 2'd2, 32'hDEAD_BEEF, 1, 2'b00, 32'h0); settle(); adv();
    drive(1, 0, 32'h10, 2'd2, 32'h0, 1, 2'b00, 32'h0); settle();
    chk("wr_htrans", 32'(htrans), 32'h2);
    chk("wr_haddr", haddr, 32'h10);
    chk("wr_hwrite", 32'(hwrite), 32'h1);
    adv();
    idle(); settle();
    chk("rd_htrans", 32'(htrans), 32'h2);
    chk("rd_hwrite", 32'(hwrite), 32'h0);
    chk("wr_hwdata", hwdata, 32'hDEAD_BEEF);
    adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'b00, 32'hDEAD_BEEF); settle();
    chk("wr_rsp_vld", 32'(rsp_vld), 32'h1);
    chk("wr_rsp_write", 32'(rsp_write), 32'h1);
    adv();
    idle(); settle();
    chk("rd_rsp_vld", 32'(rsp_vld), 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);
    adv();
    idle(); settle(); adv();

    // read with 2 wait states in its data phase, second and third requests pending
    drive(1, 0, 32'h20, 2'd2, 32'h0, 1, 2'b00, 32'h0); settle(); adv();
    drive(1, 0, 32'h24, 2'd2, 32'h0, 1, 2'b00, 32'h0); settle(); adv();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 32'h28, 2'd2, 32'h0, 0, 2'b00, 32'h0); settle();
      chk("stall_req_rdy", 32'(req_rdy), 32'h0);
      chk("stall_haddr", haddr, 32'h24);
      chk("stall_htrans", 32'(htrans), 32'h2);
      chk("stall_rsp_vld", 32'(rsp_vld), 32'h0);
      adv();
    end
    drive(1, 0, 32'h28, 2'd2, 32'h0, 1, 2'b00, 32'h2020_2020); settle();
    chk("stall_rsp_late", 32'(rsp_vld), 32'h0);
    adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'b00, 32'h2424_2424); settle();
    chk("stall_rsp0", rsp_rdata, 32'h2020_2020);
    chk("stall_haddr3", haddr, 32'h28);
    adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'b00, 32'h2828_2828); settle();
    chk("stall_rsp1", rsp_rdata, 32'h2424_2424);
    adv();
    idle(); settle();
    chk("stall_rsp2", rsp_rdata, 32'h2828_2828);
    adv();

    // two-cycle ERROR on a write with a pipelined read behind it
    drive(1, 1, 32'h30, 2'd2, 32'h1234_5678, 1, 2'b00, 32'h0); settle(); adv();
    drive(1, 0, 32'h34, 2'd2, 32'h0, 1, 2'b00, 32'h0); settle(); adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'b01, 32'h0); settle();
    chk("err_rd_haddr", haddr, 32'h34);
    chk("err_rd_htrans", 32'(htrans), 32'h2);
    adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'b01, 32'h0); settle(); adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'b00, 32'hCAFE_F00D); settle();
    chk("err_wr_vld", 32'(rsp_vld), 32'h1);
    chk("err_wr_err", 32'(rsp_err), 32'h1);
    adv();
    idle(); settle();
    chk("err_rd_vld", 32'(rsp_vld), 32'h1);
    chk("err_rd_err", 32'(rsp_err), 32'h0);
    chk("err_rd_data", rsp_rdata, 32'hCAFE_F00D);
    adv();

    // reserved size issued as word
    drive(1, 1, 32'h50, 2'd3, 32'h55AA_55AA, 1, 2'b00, 32'h0); settle(); adv();
    idle(); settle();
    chk("size3_hsize", 32'(hsize), 32'h2);
    adv();
    idle(); settle(); adv();
    idle(); settle(); adv();

    // reset asserted mid data phase
    drive(1, 0, 32'h40, 2'd2, 32'h0, 1, 2'b00, 32'h0); settle(); adv();
    idle(); settle(); adv();
    drive(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'b00, 32'h0); settle();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_hsel", 32'(hsel), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    adv();
    idle(); settle(); adv();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(); settle();
      chk("post_rst_rsp_vld", 32'(rsp_vld), 32'h0);
      adv();
    end

    // lane steering
    steer_read(32'h3, 2'd0, 1'b1, 32'h0000_0011, "steer_byte_le");
    steer_read(32'h3, 2'd0, 1'b0, 32'h0000_0044, "steer_byte_be");
    steer_read(32'h2, 2'd1, 1'b1, 32'h0000_1122, "steer_half_le");
    steer_read(32'h2, 2'd1, 1'b0, 32'h0000_3344, "steer_half_be");
    be_b = 1'b1;
    drive(1, 1, 32'h1, 2'd0, 32'h0000_00A5, 1, 2'b00, 32'h0); settle(); adv();
    idle(); settle(); adv();
    idle(); settle();
    chk("steer_wr_byte", hwdata, STEER ? 32'hA5A5_A5A5 : 32'h0000_00A5);
    adv();
    idle(); settle(); adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
